// File: rtl/l1_cache_pkg.sv
// rtl/l1_cache_pkg.sv - shared geometry, FSM states and word-merge helper for the L1 data cache
package l1_cache_pkg;

    localparam int WAYS   = 4;
    localparam int SETS   = 256;
    localparam int IDX_W  = 8;
    localparam int TAG_W  = 14;
    localparam int LINE_W = 256;
    localparam int OFF_W  = 5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOOKUP,
        S_HIT_RD,
        S_HIT_WR,
        S_WB_REQ,
        S_WB_WAIT,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_COMPLETE
    } state_e;

    // Byte-enable merge of one 32b word into a cache line.
    function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                     input logic [2:0]        word,
                                                     input logic [3:0]        be,
                                                     input logic [31:0]       wd);
        logic [LINE_W-1:0] r;
        r = line;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                r[int'(word) * 32 + b * 8 +: 8] = wd[b * 8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/l1_cache_plru.sv
// rtl/l1_cache_plru.sv - tree pseudo-LRU victim select and next-state for one 4-way set
module plru4
    import l1_cache_pkg::*;
(
    input  logic [2:0] lru_i,
    input  logic [3:0] valid_i,
    input  logic [1:0] way_i,
    output logic [1:0] victim_o,
    output logic [2:0] lru_o
);

    always_comb begin
        victim_o = 2'd0;
        if (!valid_i[0]) begin
            victim_o = 2'd0;
        end else if (!valid_i[1]) begin
            victim_o = 2'd1;
        end else if (!valid_i[2]) begin
            victim_o = 2'd2;
        end else if (!valid_i[3]) begin
            victim_o = 2'd3;
        end else if (!lru_i[0]) begin
            victim_o = lru_i[1] ? 2'd1 : 2'd0;
        end else begin
            victim_o = lru_i[2] ? 2'd3 : 2'd2;
        end
    end

    // Point every tree node on the path away from the accessed way.
    always_comb begin
        lru_o    = lru_i;
        lru_o[0] = ~way_i[1];
        if (!way_i[1]) begin
            lru_o[1] = ~way_i[0];
        end else begin
            lru_o[2] = ~way_i[0];
        end
    end

endmodule

// File: rtl/l1_cache.sv
// rtl/l1_cache.sv - 4-way set-associative write-back, write-allocate L1 data cache
module l1_cache
    import l1_cache_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   a,
    input  logic [3:0]    be,
    input  logic          read,
    input  logic          write,
    input  logic [31:0]   wd,
    output logic [31:0]   rd,
    output logic          rd_valid_d,
    output logic          ready_d,
    output logic [31:0]   mm_a,
    output logic          mm_read_d,
    output logic          mm_write_d,
    output logic [255:0]  mm_writedata,
    input  logic [255:0]  mm_readdata,
    input  logic          mm_readdata_valid,
    input  logic          mm_ready
);

    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [LINE_W-1:0] data_q  [WAYS][SETS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [2:0]        lru_q   [SETS];

    state_e       state_q, state_d;
    logic [31:2]  addr_q;
    logic [3:0]   be_q;
    logic [31:0]  wd_q;
    logic         wr_q;
    logic [1:0]   victim_q;

    logic         rdy_q, rdy_d;
    logic         rdv_q, rdv_d;
    logic         mmrd_q, mmrd_d;
    logic         mmwr_q, mmwr_d;
    logic [31:0]  mma_q, mma_d;
    logic [31:0]  rd_q, rd_d;

    logic             unused_addr_bits;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [2:0]       word;
    logic             accept;
    logic             hit;
    logic [1:0]       hit_way;
    logic [1:0]       victim;
    logic [1:0]       access_way;
    logic [2:0]       lru_next;
    logic             fill_now;
    logic [31:0]      fill_addr;

    assign unused_addr_bits = ^a[1:0];
    assign idx       = addr_q[12:5];
    assign tag       = addr_q[26:13];
    assign word      = addr_q[4:2];
    assign accept    = rdy_q & (read | write);
    assign fill_now  = (state_q == S_FILL_WAIT) & mm_readdata_valid;
    assign fill_addr = {addr_q[31:5], 5'b00000};

    always_comb begin
        hit     = 1'b0;
        hit_way = 2'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[idx][w] && tag_q[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = 2'(w);
            end
        end
    end

    assign access_way = (state_q == S_FILL_WAIT) ? victim_q : hit_way;

    plru4 u_plru (
        .lru_i    (lru_q[idx]),
        .valid_i  (valid_q[idx]),
        .way_i    (access_way),
        .victim_o (victim),
        .lru_o    (lru_next)
    );

    always_comb begin
        state_d = state_q;
        rdy_d   = 1'b0;
        rdv_d   = 1'b0;
        mmrd_d  = mmrd_q;
        mmwr_d  = mmwr_q;
        mma_d   = mma_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE, S_HIT_RD, S_HIT_WR: begin
                if (accept) begin
                    state_d = S_LOOKUP;
                end else begin
                    state_d = S_IDLE;
                    rdy_d   = 1'b1;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    rdy_d = 1'b1;
                    if (!wr_q) begin
                        rd_d    = data_q[hit_way][idx][{word, 5'b00000} +: 32];
                        rdv_d   = 1'b1;
                        state_d = S_HIT_RD;
                    end else begin
                        state_d = S_HIT_WR;
                    end
                end else if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                    mmwr_d  = 1'b1;
                    mma_d   = {5'b00000, tag_q[victim][idx], idx, 5'b00000};
                    state_d = S_WB_REQ;
                end else begin
                    mmrd_d  = 1'b1;
                    mma_d   = fill_addr;
                    state_d = S_FILL_REQ;
                end
            end
            S_WB_REQ: begin
                if (mm_ready) begin
                    mmwr_d  = 1'b0;
                    state_d = S_WB_WAIT;
                end
            end
            S_WB_WAIT: begin
                if (mm_ready) begin
                    mmrd_d  = 1'b1;
                    mma_d   = fill_addr;
                    state_d = S_FILL_REQ;
                end
            end
            S_FILL_REQ: begin
                if (mm_ready) begin
                    mmrd_d  = 1'b0;
                    state_d = S_FILL_WAIT;
                end
            end
            S_FILL_WAIT: begin
                if (mm_readdata_valid) begin
                    rd_d    = mm_readdata[{word, 5'b00000} +: 32];
                    rdv_d   = ~wr_q;
                    state_d = S_COMPLETE;
                end
            end
            S_COMPLETE: begin
                rdy_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rdy_q    <= 1'b0;
            rdv_q    <= 1'b0;
            mmrd_q   <= 1'b0;
            mmwr_q   <= 1'b0;
            mma_q    <= '0;
            rd_q     <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            wd_q     <= '0;
            wr_q     <= 1'b0;
            victim_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            rdv_q   <= rdv_d;
            mmrd_q  <= mmrd_d;
            mmwr_q  <= mmwr_d;
            mma_q   <= mma_d;
            rd_q    <= rd_d;
            if (accept) begin
                addr_q <= a[31:2];
                be_q   <= be;
                wd_q   <= wd;
                wr_q   <= write & ~read;
            end
            if (state_q == S_LOOKUP) begin
                victim_q <= victim;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                lru_q[s]   <= '0;
            end
        end else if (state_q == S_LOOKUP && hit) begin
            lru_q[idx] <= lru_next;
            if (wr_q) begin
                dirty_q[idx][hit_way] <= 1'b1;
            end
        end else if (fill_now) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= wr_q;
            lru_q[idx]             <= lru_next;
        end
    end

    // Line storage carries no reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_LOOKUP && hit && wr_q) begin
            data_q[hit_way][idx] <= merge_word(data_q[hit_way][idx], word, be_q, wd_q);
        end
        if (!reset && fill_now) begin
            data_q[victim_q][idx] <= wr_q ? merge_word(mm_readdata, word, be_q, wd_q) : mm_readdata;
            tag_q[victim_q][idx]  <= tag;
        end
    end

    assign rd           = rd_q;
    assign rd_valid_d   = rdv_q;
    assign ready_d      = rdy_q;
    assign mm_a         = mma_q;
    assign mm_read_d    = mmrd_q;
    assign mm_write_d   = mmwr_q;
    assign mm_writedata = data_q[victim_q][idx];

endmodule

// File: tb/tb_l1_cache.sv
// tb/tb_l1_cache.sv - scoreboard bench for l1_cache against a flat word memory model
module tb_l1_cache;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  a = '0;
    logic [3:0]   be = '0;
    logic         read = 1'b0;
    logic         write = 1'b0;
    logic [31:0]  wd = '0;
    logic [31:0]  rd;
    logic         rd_valid_d;
    logic         ready_d;
    logic [31:0]  mm_a;
    logic         mm_read_d;
    logic         mm_write_d;
    logic [255:0] mm_writedata;
    logic [255:0] mm_readdata;
    logic         mm_readdata_valid;
    logic         mm_ready;

    l1_cache dut (
        .clk               (clk),
        .reset             (reset),
        .a                 (a),
        .be                (be),
        .read              (read),
        .write             (write),
        .wd                (wd),
        .rd                (rd),
        .rd_valid_d        (rd_valid_d),
        .ready_d           (ready_d),
        .mm_a              (mm_a),
        .mm_read_d         (mm_read_d),
        .mm_write_d        (mm_write_d),
        .mm_writedata      (mm_writedata),
        .mm_readdata       (mm_readdata),
        .mm_readdata_valid (mm_readdata_valid),
        .mm_ready          (mm_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [255:0] mem_line [int];
    logic [31:0]  ref_mem  [int];
    logic [31:0]  exp_q    [$];

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        if (wa == 32'h44) return 32'h11223344;
        return {wa[15:0] ^ 16'h5A5A, ~wa[15:0]};
    endfunction

    function automatic logic [255:0] mem_get(input logic [31:0] la);
        logic [255:0] r;
        if (mem_line.exists(int'(la >> 5))) return mem_line[int'(la >> 5)];
        for (int w = 0; w < 8; w++) r[w * 32 +: 32] = init_word(la + 32'(w * 4));
        return r;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        if (ref_mem.exists(int'(addr >> 2))) return ref_mem[int'(addr >> 2)];
        return init_word({addr[31:2], 2'b00});
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] la);
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w * 32 +: 32] = ref_word(la + 32'(w * 4));
        return r;
    endfunction

    task automatic ref_write(input logic [31:0] addr, input logic [3:0] b, input logic [31:0] d);
        logic [31:0] w;
        w = ref_word(addr);
        for (int i = 0; i < 4; i++) if (b[i]) w[i * 8 +: 8] = d[i * 8 +: 8];
        ref_mem[int'(addr >> 2)] = w;
    endtask

    // Main-memory responder: accepts requests, returns fills a few cycles later.
    int           cyc = 0;
    int           fill_cnt = 0;
    logic [31:0]  fill_addr;
    int           n_fill = 0, n_wb = 0, seq = 0, fill_seq = 0, wb_seq = 0;
    int           fill_cyc = 0, rdv_cyc = 0;
    logic [31:0]  last_fill_a = '0, last_wb_a = '0;
    logic [255:0] last_wb_d = '0;
    bit           stall_en = 0, hold_nrdy = 0, both_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        mm_ready = 1'b1;
        mm_readdata_valid = 1'b0;
        mm_readdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mm_readdata_valid = 1'b0;
            if (reset) begin
                fill_cnt = 0;
            end else if (fill_cnt > 0) begin
                fill_cnt--;
                if (fill_cnt == 0) begin
                    mm_readdata = mem_get(fill_addr);
                    mm_readdata_valid = 1'b1;
                    fill_cyc = cyc;
                end
            end
            if (hold_nrdy) mm_ready = 1'b0;
            else if (stall_en) mm_ready = ($urandom_range(0, 2) != 0);
            else mm_ready = 1'b1;
            if (!reset && mm_ready && mm_write_d) begin
                mem_line[int'(mm_a >> 5)] = mm_writedata;
                n_wb++;
                last_wb_a = mm_a;
                last_wb_d = mm_writedata;
                wb_seq = seq++;
            end
            if (!reset && mm_ready && mm_read_d) begin
                fill_addr = mm_a;
                fill_cnt = 2 + int'($urandom_range(0, 2));
                n_fill++;
                last_fill_a = mm_a;
                fill_seq = seq++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mm_read_d && mm_write_d) both_seen = 1;
            if (rd_valid_d) begin
                rdv_cyc = cyc;
                if (exp_q.size() == 0) check("rd_unexpected", rd_valid_d, 1'b0);
                else check("rd_data", rd, exp_q.pop_front());
            end
        end
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready_d && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready_d) check(tag, ready_d, 1'b1);
    endtask

    task automatic issue(input bit do_rd, input bit do_wr, input logic [31:0] addr,
                         input logic [3:0] b, input logic [31:0] d);
        wait_ready("ready_timeout");
        read = do_rd;
        write = do_wr;
        a = addr;
        be = b;
        wd = d;
        if (do_rd) exp_q.push_back(ref_word(addr));
        else if (do_wr) ref_write(addr, b, d);
        @(posedge clk);
        #1;
        read = 1'b0;
        write = 1'b0;
        a = $urandom;
        be = 4'($urandom);
        wd = $urandom;
    endtask

    function automatic logic arrays_nonzero();
        logic any = 1'b0;
        for (int s = 0; s < 256; s++) any |= (|dut.valid_q[s]) | (|dut.dirty_q[s]) | (|dut.lru_q[s]);
        return any;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int f0, w0;
        logic [255:0] exp_line;
        bit traffic;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_low", ready_d, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready_rise", ready_d, 1'b1);
        check("rst_mm_req", {mm_read_d, mm_write_d, rd_valid_d}, 3'b000);
        check("rst_mm_a", mm_a, 32'h0);
        check("rst_arrays", arrays_nonzero(), 1'b0);

        f0 = n_fill;
        issue(1, 0, 32'h40, 4'h0, 32'h0);
        wait_ready("cold_wait");
        check("cold_fill_cnt", n_fill - f0, 1);
        check("cold_fill_addr", last_fill_a, 32'h40);
        check("cold_miss_lat", rdv_cyc - fill_cyc, 1);
        check("cold_valid", dut.valid_q[2][0], 1'b1);
        check("cold_tag", dut.tag_q[0][2], 14'h0);

        f0 = n_fill;
        issue(1, 0, 32'h40, 4'h0, 32'h0);
        check("hit_rdv_early", rd_valid_d, 1'b0);
        @(posedge clk);
        #1;
        check("hit_rdv", rd_valid_d, 1'b1);
        check("hit_ready", ready_d, 1'b1);
        check("hit_no_mm", n_fill - f0, 0);

        issue(0, 1, 32'h44, 4'b0011, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        check("wr_tput", ready_d, 1'b1);
        check("wr_dirty", dut.dirty_q[2][0], 1'b1);
        issue(1, 0, 32'h44, 4'h0, 32'h0);
        wait_ready("wr_rd_wait");
        check("wr_no_mm", n_fill - f0, 0);

        for (int i = 0; i < 4; i++) begin
            issue(1, 0, 32'(i) * 32'h2000, 4'h0, 32'h0);
            wait_ready("set0_wait");
        end
        check("lru_after_4", dut.lru_q[0], 3'b000);
        issue(1, 0, 32'h0, 4'h0, 32'h0);
        wait_ready("reread_wait");
        check("lru_reread0", dut.lru_q[0], 3'b011);

        for (int i = 0; i < 4; i++) begin
            issue(0, 1, 32'(i) * 32'h2000 + 32'(i * 4), 4'hF, $urandom);
            wait_ready("dirty_wait");
        end
        check("lru_dirty4", dut.lru_q[0], 3'b000);
        exp_line = ref_line(32'h0);
        f0 = n_fill;
        w0 = n_wb;
        issue(1, 0, 32'h8000, 4'h0, 32'h0);
        wait_ready("evict_wait");
        check("evict_wb_cnt", n_wb - w0, 1);
        check("evict_wb_addr", last_wb_a, 32'h0);
        check("evict_wb_data", last_wb_d, exp_line);
        check("evict_fill_addr", last_fill_a, 32'h8000);
        check("evict_order", wb_seq < fill_seq, 1'b1);
        check("evict_tag", dut.tag_q[0][0], 14'h4);
        check("evict_clean", dut.dirty_q[0][0], 1'b0);
        issue(1, 0, 32'h0, 4'h0, 32'h0);
        issue(1, 0, 32'h4008, 4'h0, 32'h0);
        issue(1, 0, 32'h2004, 4'h0, 32'h0);
        wait_ready("roundtrip_wait");

        issue(1, 1, 32'h48, 4'hF, 32'hCAFEF00D);
        issue(1, 0, 32'h48, 4'h0, 32'h0);
        wait_ready("both_wait");

        stall_en = 1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra;
            bit is_wr;
            ra = 32'($urandom_range(0, 5)) * 32'h2000 + 32'($urandom_range(0, 3)) * 32'h20
               + 32'($urandom_range(0, 7)) * 32'h4;
            is_wr = ($urandom_range(0, 1) == 1);
            issue(!is_wr, is_wr, ra, 4'($urandom_range(1, 15)), $urandom);
        end
        wait_ready("rand_wait");
        stall_en = 0;
        repeat (3) @(posedge clk);
        #1;

        hold_nrdy = 1;
        issue(1, 0, 32'h0001_0000, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("midop_req", mm_read_d | mm_write_d, 1'b1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        hold_nrdy = 0;
        exp_q.delete();
        f0 = n_fill;
        w0 = n_wb;
        traffic = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (mm_read_d || mm_write_d) traffic = 1;
        end
        check("midop_quiet", traffic, 1'b0);
        check("midop_accepts", (n_fill - f0) + (n_wb - w0), 0);
        check("midop_ready", ready_d, 1'b1);
        check("midop_arrays", arrays_nonzero(), 1'b0);

        check("sb_empty", exp_q.size(), 0);
        check("mm_exclusive", both_seen, 1'b0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
